conv_accumulator: RTL and testbench
===================================

# conv_accumulator

Windowed multiply-accumulate stage of the convolution datapath. It consumes the stream of signed tap products (pixel × weight) and sums every TAPS consecutive products into one saturated partial sum. Each finished sum goes out over a valid/ready handshake to the downstream select/mux stage, which routes ACC_WIDTH-bit results. It replaces the ad-hoc "load vs. add" select logic with one self-counting stage.

## Interface
- `IN_WIDTH`, 16, width of each signed product on `in_data`; must be < `ACC_WIDTH`
- `ACC_WIDTH`, 30, width of the signed accumulator and `out_data`
- `TAPS`, 9, products per window (kernel size, e.g. 3×3); ≥ 1
- `clk`  in  1  single clock; all state on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `clear`  in  1  synchronous abort: discard partial window and any pending result
- `in_valid`  in  1  `in_data` holds a product
- `in_ready`  out  1  stage accepts a product this cycle
- `in_data`  in  IN_WIDTH  signed two's-complement product
- `out_valid`  out  1  `out_data`/`out_ovf` hold a completed window sum
- `out_ready`  in  1  downstream consumes the result this cycle
- `out_data`  out  ACC_WIDTH  signed saturated window sum
- `out_ovf`  out  1  at least one saturation occurred in this window

## Operation
- Input accept: `in_valid && in_ready`. Output accept: `out_valid && out_ready`.
- Tap counter `cnt` counts 0..TAPS-1 and selects load or add per accepted product:
  - `cnt==0`: `acc <= sext(in_data)`, `ovf <= 0`.
  - Otherwise: compute `acc + sext(in_data)` at ACC_WIDTH+1 bits. On positive overflow clamp to 2^(ACC_WIDTH-1)-1; on negative overflow clamp to -2^(ACC_WIDTH-1). In either case set `ovf`, which stays set until the next window load.
- On the accept with `cnt==TAPS-1`:
  - The result (post-add/clamp value) goes to the output register.
  - `out_valid <= 1`.
  - `cnt` wraps to 0.
  - With TAPS=1, every product completes a window.
- FSM:
  - ACCUM: `in_ready=1`, `out_valid=0`. The last tap is accepted → HOLD.
  - HOLD: `out_valid=1`, `out_data`/`out_ovf` stable. `in_ready = out_ready` (combinational pass-through).
    - Output accept with no input accept → ACCUM.
    - Output accept and input accept in the same cycle → the accepted product loads as tap 0 of the next window. Stay in HOLD only if TAPS=1, presenting the new result; otherwise go to ACCUM with `cnt=1`.
- Priority: `rst_n` low > `clear` > normal operation.
  - `clear`: state→ACCUM, `cnt=0`, `out_valid=0`. Any product presented that cycle is ignored (`in_ready` is still driven per state, but the accept is discarded).
- Reset values: `out_valid=0`, `out_data=0`, `out_ovf=0`, `cnt=0`, `acc=0`, state ACCUM, so `in_ready=1` after reset.
- Reset or `clear` mid-window: partial sum discarded, no output produced. The next accepted product is tap 0.

## Timing
- `out_valid` rises the cycle after the last tap is accepted (latency 1).
- `out_data` and `out_ovf` are registered, with no combinational path from `in_data`.
- Sustained throughput with `out_ready=1` and `in_valid=1`: one result per TAPS cycles, no bubbles.
- Under backpressure, `out_data`, `out_ovf` and `out_valid` are held unchanged until accepted. `in_valid`/`in_data` may change freely while `in_ready=0`.
- Only combinational path is `out_ready` → `in_ready` (in HOLD).
- Throughput at TAPS=1: one result per cycle.

## Test plan
- Basic window (defaults): products 1..9 on consecutive cycles, `out_ready=1` → `out_data=45`, `out_ovf=0`, `out_valid` high for exactly 1 cycle, on the cycle after the 9th accept.
- Negative / back-to-back: nine × -32768, then nine × 3 with no gap →
  - `out_data=-294912`, then `27`.
  - No idle input cycles; `in_ready` stays high throughout.
- Backpressure: finish window of nine × 1 with `out_ready=0` for 5 cycles →
  - `out_data=9` stable and `in_ready=0` throughout.
  - When `out_ready=1` with `in_valid=1`, that product is accepted as tap 0 in the same cycle.
- Saturation: `ACC_WIDTH=18`, nine × 32767 → `out_data=131071`, `out_ovf=1`. The next window of nine × 1 gives `out_data=9`, `out_ovf=0`.
- Clear / reset mid-window:
  - Four taps of 100, `clear` pulse, then nine × 2 → `out_data=18`.
  - Repeat with `rst_n=0` for 1 cycle instead of `clear` → same result; all outputs 0 during reset.
- TAPS=1 edge: stream 5, -7, 12 with `out_ready=1` → outputs 5, -7, 12 on consecutive cycles, each 1 cycle after its input.

Source files
------------

// File: rtl/conv_accumulator.sv
// conv_accumulator
//   Sums every TAPS consecutive signed tap products into one saturated
//   partial sum and hands it downstream over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   clear      synchronous abort of the partial window and any pending result
//   in_valid   in_data holds a product
//   in_ready   product accepted this cycle (follows out_ready while holding)
//   in_data    signed product, IN_WIDTH bits
//   out_valid  out_data/out_ovf hold a completed window sum
//   out_ready  downstream consumes the result this cycle
//   out_data   signed saturated window sum, ACC_WIDTH bits
//   out_ovf    a saturation occurred somewhere in this window
module conv_accumulator #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 30,
    parameter int TAPS      = 9
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_ovf
);

    localparam int CNT_W = (TAPS > 1) ? $clog2(TAPS) : 1;
    localparam logic [CNT_W-1:0]     LAST    = CNT_W'(TAPS - 1);
    localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    logic [ACC_WIDTH-1:0] ext;
    logic [ACC_WIDTH:0]   sum;
    logic [ACC_WIDTH-1:0] nxt_acc;
    logic                 nxt_ovf;
    logic                 in_acc;
    logic                 out_acc;

    // While holding a result, a new product may only enter if the result
    // leaves in the same cycle, so in_ready mirrors out_ready.
    assign in_ready = (state == ACCUM) || out_ready;
    assign in_acc   = in_valid && in_ready;
    assign out_acc  = out_valid && out_ready;

    // Load on tap 0, otherwise add with one guard bit; a guard/sign
    // disagreement means the true sum left the ACC_WIDTH range.
    always_comb begin
        ext     = {{(ACC_WIDTH-IN_WIDTH){in_data[IN_WIDTH-1]}}, in_data};
        sum     = {acc[ACC_WIDTH-1], acc} + {ext[ACC_WIDTH-1], ext};
        nxt_acc = sum[ACC_WIDTH-1:0];
        nxt_ovf = ovf;
        if (cnt == '0) begin
            nxt_acc = ext;
            nxt_ovf = 1'b0;
        end else if (sum[ACC_WIDTH] != sum[ACC_WIDTH-1]) begin
            nxt_acc = sum[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
            nxt_ovf = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACCUM;
            cnt       <= '0;
            acc       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ovf   <= 1'b0;
        end else if (clear) begin
            state     <= ACCUM;
            cnt       <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_acc) begin
                out_valid <= 1'b0;
                state     <= ACCUM;
            end
            // In HOLD an input accept implies an output accept and cnt==0,
            // so the product naturally starts the next window here.
            if (in_acc) begin
                acc <= nxt_acc;
                ovf <= nxt_ovf;
                if (cnt == LAST) begin
                    cnt       <= '0;
                    out_data  <= nxt_acc;
                    out_ovf   <= nxt_ovf;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv_accumulator.sv
// Directed bench: instance 0 = defaults, 1 = ACC_WIDTH 18, 2 = TAPS 1.
module tb_conv_accumulator;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic        iv   [3];
    logic [15:0] id   [3];
    logic        ordy [3];
    logic        irdy [3];
    logic        ov   [3];
    logic        oo   [3];
    logic [29:0] od_a;
    logic [17:0] od_b;
    logic [29:0] od_c;
    int          od   [3];

    int n_err = 0;
    int n_chk = 0;

    assign od[0] = $signed(od_a);
    assign od[1] = $signed(od_b);
    assign od[2] = $signed(od_c);

    conv_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(30), .TAPS(9)) u_a (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(iv[0]), .in_ready(irdy[0]), .in_data(id[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od_a), .out_ovf(oo[0]));

    conv_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(18), .TAPS(9)) u_b (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(iv[1]), .in_ready(irdy[1]), .in_data(id[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od_b), .out_ovf(oo[1]));

    conv_accumulator #(.IN_WIDTH(16), .ACC_WIDTH(30), .TAPS(1)) u_c (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .in_valid(iv[2]), .in_ready(irdy[2]), .in_data(id[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od_c), .out_ovf(oo[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // n products of value d on consecutive cycles (inputs change at negedge)
    task automatic send(input int k, input int d, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            iv[k] = 1'b1;
            id[k] = d[15:0];
        end
    endtask

    // Drop in_valid and check the result that the last send produced
    task automatic obs(input int k, input string tag, input int exp_d, input int exp_o);
        @(negedge clk);
        iv[k] = 1'b0;
        chk({tag, ".valid"}, int'(ov[k]), 1);
        chk({tag, ".data"},  od[k], exp_d);
        chk({tag, ".ovf"},   int'(oo[k]), exp_o);
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            iv[k]   = 1'b0;
            id[k]   = '0;
            ordy[k] = 1'b1;
        end
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk("rst.valid", int'(ov[k]), 0);
            chk("rst.data",  od[k], 0);
            chk("rst.ovf",   int'(oo[k]), 0);
            chk("rst.ready", int'(irdy[k]), 1);
        end
        rst_n = 1'b1;

        // Basic window 1..9 = 45, valid for exactly one cycle
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            chk("basic.early", int'(ov[0]), 0);
            iv[0] = 1'b1;
            id[0] = 16'(i);
        end
        obs(0, "basic", 45, 0);
        @(negedge clk);
        chk("basic.pulse", int'(ov[0]), 0);

        // Back-to-back negative then small window, no bubbles
        for (int j = 0; j < 18; j++) begin
            @(negedge clk);
            chk("b2b.ready", int'(irdy[0]), 1);
            if (j == 9) begin
                chk("b2b.v1", int'(ov[0]), 1);
                chk("b2b.d1", od[0], -294912);
            end
            iv[0] = 1'b1;
            id[0] = (j < 9) ? 16'h8000 : 16'd3;
        end
        obs(0, "b2b2", 27, 0);
        @(negedge clk);
        chk("b2b.drain", int'(ov[0]), 0);

        // Backpressure: result held, input stalled, then joint accept
        ordy[0] = 1'b0;
        send(0, 1, 9);
        @(negedge clk);
        iv[0] = 1'b1;
        id[0] = 16'd5;
        for (int i = 0; i < 5; i++) begin
            chk("bp.valid", int'(ov[0]), 1);
            chk("bp.data",  od[0], 9);
            chk("bp.ready", int'(irdy[0]), 0);
            @(negedge clk);
        end
        chk("bp.hold", od[0], 9);
        ordy[0] = 1'b1;
        #1;
        chk("bp.pass", int'(irdy[0]), 1);
        send(0, 1, 8);
        obs(0, "bp.tap0", 13, 0);

        // Clear mid-window; the product presented with clear is dropped
        send(0, 100, 4);
        @(negedge clk);
        clear = 1'b1;
        iv[0] = 1'b1;
        id[0] = 16'd100;
        @(negedge clk);
        clear = 1'b0;
        iv[0] = 1'b0;
        chk("clr.valid", int'(ov[0]), 0);
        send(0, 2, 9);
        obs(0, "clr", 18, 0);

        // Reset mid-window
        send(0, 100, 4);
        @(negedge clk);
        rst_n = 1'b0;
        iv[0] = 1'b0;
        @(negedge clk);
        chk("rst2.data",  od[0], 0);
        chk("rst2.valid", int'(ov[0]), 0);
        chk("rst2.ovf",   int'(oo[0]), 0);
        rst_n = 1'b1;
        send(0, 2, 9);
        obs(0, "rst2", 18, 0);

        // Saturation at ACC_WIDTH 18, and ovf cleared by the next window
        send(1, 32767, 9);
        obs(1, "satp", 131071, 1);
        send(1, 1, 9);
        obs(1, "sat.next", 9, 0);
        send(1, -32768, 9);
        obs(1, "satn", -131072, 1);

        // TAPS=1: every product is a window, one result per cycle
        @(negedge clk);
        iv[2] = 1'b1;
        id[2] = 16'd5;
        @(negedge clk);
        chk("t1.v0", int'(ov[2]), 1);
        chk("t1.d0", od[2], 5);
        chk("t1.r0", int'(irdy[2]), 1);
        id[2] = 16'hfff9;
        @(negedge clk);
        chk("t1.v1", int'(ov[2]), 1);
        chk("t1.d1", od[2], -7);
        id[2] = 16'd12;
        @(negedge clk);
        iv[2] = 1'b0;
        chk("t1.v2", int'(ov[2]), 1);
        chk("t1.d2", od[2], 12);
        @(negedge clk);
        chk("t1.drain", int'(ov[2]), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
